sram_arbiter: RTL

//  Shares one sram controller (single 16-bit word port over 8-bit external SRAM) between NREQ requesters.

---
 rtl/p3p_pkg.sv | 18 +
 rtl/sram_arbiter_rr_pick.sv | 39 +++
 rtl/sram_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/p3p_pkg.sv
// Shared types for the sram arbiter slice.
//   num      : signed 16-bit data word moved between requesters and the sram controller
//   SRAM_AW  : byte-address width of the external sram
//   state_t  : arbiter FSM states
package p3p_pkg;

    typedef logic signed [15:0] num;

    localparam int SRAM_AW = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req : per-requester request vector
//   ptr : index of the requester that gets first look this round
//   win : one-hot winner (all zero when no request)
//   idx : binary index of the winner
//   any : at least one request present
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Candidate index, one bit wider so ptr+k can be folded back below N.
    logic [IW:0] cand;

    always_comb begin
        win  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any                 = 1'b1;
                idx                 = cand[IW-1:0];
                win[cand[IW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram controller word port between NREQ requesters.
// One operation in flight: IDLE -> ISSUE (one-cycle strobe) -> WAIT (until sram_ready
// or timeout) -> ACK (one-cycle ack to owner) -> IDLE.
//   clk, reset          : clock, asynchronous active-low reset
//   req/we/addr/wdata   : per-requester command, held until ack
//   gnt/ack/rdata       : grant (one-hot), completion pulse, last read word
//   busy/err            : not idle, sticky timeout flag
//   data_addr/data_in   : latched command toward the controller
//   write_data/read_data: one-cycle strobes toward the controller
//   sram_ready/sram_idle/data_out : controller status and read word
module sram_arbiter
    import p3p_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               we,
    input  logic [NREQ-1:0][SRAM_AW-1:0]  addr,
    input  logic [NREQ-1:0][15:0]         wdata,
    output logic [NREQ-1:0]               gnt,
    output logic [NREQ-1:0]               ack,
    output num                            rdata,
    output logic                          busy,
    output logic                          err,
    output logic [SRAM_AW-1:0]            data_addr,
    output logic                          write_data,
    output logic                          read_data,
    output num                            data_in,
    input  logic                          sram_ready,
    input  logic                          sram_idle,
    input  num                            data_out
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [SRAM_AW-1:0]   data_addr_q, data_addr_d;
    num                   data_in_q, data_in_d;
    num                   rdata_q, rdata_d;
    logic                 write_q, write_d;
    logic                 read_q, read_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [NREQ-1:0]      pick_win;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 grant_now;
    logic                 timeout_hit;
    logic [IW:0]          ptr_nxt;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A grant needs both a request and a free controller.
    assign grant_now = pick_any && sram_idle;

    // cnt_q counts completed WAIT cycles; abort on the TIMEOUT-th one.
    assign timeout_hit = (cnt_q + CW'(1)) == CW'(TIMEOUT);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            ack_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            we_q        <= 1'b0;
            data_addr_q <= '0;
            data_in_q   <= '0;
            rdata_q     <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            data_addr_q <= data_addr_d;
            data_in_q   <= data_in_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            read_q      <= read_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_now) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (sram_ready || timeout_hit) state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values. Strobes and ack are computed one state early
    // so that they are registered and appear in ISSUE and ACK respectively.
    always_comb begin
        gnt_d       = gnt_q;
        ack_d       = '0;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        we_d        = we_q;
        data_addr_d = data_addr_q;
        data_in_d   = data_in_q;
        rdata_d     = rdata_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        err_d       = err_q;
        cnt_d       = '0;
        ptr_nxt     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    gnt_d       = pick_win;
                    owner_d     = pick_idx;
                    we_d        = we[pick_idx];
                    data_addr_d = addr[pick_idx];
                    data_in_d   = wdata[pick_idx];
                    write_d     = we[pick_idx];
                    read_d      = ~we[pick_idx];
                end
            end
            ST_ISSUE: begin
                cnt_d = '0;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (sram_ready) begin
                    if (!we_q) begin
                        rdata_d = data_out;
                    end
                    ack_d = gnt_q;
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                    ack_d = gnt_q;
                end
            end
            ST_ACK: begin
                gnt_d   = '0;
                ptr_nxt = {1'b0, owner_q} + (IW+1)'(1);
                if (ptr_nxt >= (IW+1)'(NREQ)) begin
                    ptr_nxt = '0;
                end
                ptr_d = ptr_nxt[IW-1:0];
            end
            default: ;
        endcase
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign err        = err_q;
    assign data_addr  = data_addr_q;
    assign data_in    = data_in_q;
    assign write_data = write_q;
    assign read_data  = read_q;

endmodule
